// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, grant IDs and fetch constants for the memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, RD0, RD1, WR1} state_t;
  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_M0 = 2'd1;
  localparam logic [1:0] GNT_M1 = 2'd2;
  localparam logic [3:0] FETCH_SIZE = 4'd4;
  localparam logic FETCH_UNSIGNED = 1'b1;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin picker, i_last high means m1 won the previous grant
module rr_pick2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_valid,
  output logic o_sel
);
  assign o_valid = i_req0 | i_req1;
  assign o_sel = i_req1 & (~i_req0 | ~i_last);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: routes one of two masters (IFU read, LSU read/write) to the shared memory slave
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_arvalid,
  input  logic [ADDR_W-1:0] m0_araddr,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rresp,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic              m1_arvalid,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_load_unsign,
  input  logic [3:0]        m1_arsize,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rresp,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  input  logic              m1_awvalid,
  input  logic [ADDR_W-1:0] m1_awaddr,
  output logic              m1_awready,
  input  logic              m1_wvalid,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [31:0]       m1_wstrb,
  output logic              m1_wready,
  output logic              m1_bresp,
  output logic              m1_bvalid,
  input  logic              m1_bready,
  output logic              s_arvalid,
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_load_unsign,
  output logic [3:0]        s_arsize,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rresp,
  input  logic              s_rvalid,
  output logic              s_rready,
  output logic              s_awvalid,
  output logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awready,
  output logic              s_wvalid,
  output logic [DATA_W-1:0] s_wdata,
  output logic [31:0]       s_wstrb,
  input  logic              s_wready,
  input  logic              s_bresp,
  input  logic              s_bvalid,
  output logic              s_bready,
  output logic [1:0]        grant,
  output logic              busy
);
  state_t r_state, w_next;
  logic r_last, w_pick_v, w_pick_m1, w_rd0, w_rd1, w_wr1;
  rr_pick2 u_pick (
    .i_req0 (m0_arvalid),
    .i_req1 (m1_arvalid | m1_awvalid),
    .i_last (r_last),
    .o_valid(w_pick_v),
    .o_sel  (w_pick_m1)
  );
  assign w_rd0 = r_state == RD0;
  assign w_rd1 = r_state == RD1;
  assign w_wr1 = r_state == WR1;
  // next state: arbitrate in IDLE, return to IDLE on the owner's response handshake
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && w_pick_v) w_next = w_pick_m1 ? (m1_awvalid ? WR1 : RD1) : RD0;
    if (((w_rd0 | w_rd1) & s_rvalid & s_rready) | (w_wr1 & s_bvalid & s_bready)) w_next = IDLE;
  end
  // state register; the round-robin pointer moves only when a grant is taken
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_last <= 1'b1;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next != IDLE) r_last <= w_pick_m1;
    end
  end
  assign s_arvalid = w_rd0 ? m0_arvalid : w_rd1 & m1_arvalid;
  assign s_araddr = w_rd0 ? m0_araddr : w_rd1 ? m1_araddr : '0;
  assign s_load_unsign = w_rd0 ? FETCH_UNSIGNED : w_rd1 & m1_load_unsign;
  assign s_arsize = w_rd0 ? FETCH_SIZE : w_rd1 ? m1_arsize : '0;
  assign s_rready = w_rd0 ? m0_rready : w_rd1 & m1_rready;
  assign s_awvalid = w_wr1 & m1_awvalid;
  assign s_awaddr = w_wr1 ? m1_awaddr : '0;
  assign s_wvalid = w_wr1 & m1_wvalid;
  assign s_wdata = w_wr1 ? m1_wdata : '0;
  assign s_wstrb = w_wr1 ? m1_wstrb : '0;
  assign s_bready = w_wr1 & m1_bready;
  assign m0_arready = w_rd0 & s_arready;
  assign m0_rdata = w_rd0 ? s_rdata : '0;
  assign m0_rresp = w_rd0 & s_rresp;
  assign m0_rvalid = w_rd0 & s_rvalid;
  assign m1_arready = w_rd1 & s_arready;
  assign m1_rdata = w_rd1 ? s_rdata : '0;
  assign m1_rresp = w_rd1 & s_rresp;
  assign m1_rvalid = w_rd1 & s_rvalid;
  assign m1_awready = w_wr1 & s_awready;
  assign m1_wready = w_wr1 & s_wready;
  assign m1_bresp = w_wr1 & s_bresp;
  assign m1_bvalid = w_wr1 & s_bvalid;
  assign grant = w_rd0 ? GNT_M0 : (w_rd1 | w_wr1) ? GNT_M1 : GNT_NONE;
  assign busy = r_state != IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table, directed and random-vs-model checks of mem_arbiter
module tb_mem_arbiter;
  logic clk = 0, reset;
  logic m0_arvalid, m0_arready, m0_rresp, m0_rvalid, m0_rready;
  logic [31:0] m0_araddr, m0_rdata;
  logic m1_arvalid, m1_load_unsign, m1_arready, m1_rresp, m1_rvalid, m1_rready;
  logic [31:0] m1_araddr, m1_rdata, m1_awaddr, m1_wdata, m1_wstrb;
  logic [3:0] m1_arsize, s_arsize;
  logic m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bresp, m1_bvalid, m1_bready;
  logic s_arvalid, s_load_unsign, s_arready, s_rresp, s_rvalid, s_rready;
  logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata, s_wstrb;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bresp, s_bvalid, s_bready;
  logic [1:0] grant;
  logic busy;
  logic [214:0] act;
  int errors = 0, checks = 0;
  int owner, last;
  always #5 clk = ~clk;
  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_load_unsign(m1_load_unsign),
    .m1_arsize(m1_arsize), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awready(m1_awready),
    .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_load_unsign(s_load_unsign),
    .s_arsize(s_arsize), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .grant(grant), .busy(busy)
  );
  assign act = {s_arvalid, s_araddr, s_load_unsign, s_arsize, s_rready, s_awvalid, s_awaddr,
                s_wvalid, s_wdata, s_wstrb, s_bready, m0_arready, m0_rdata, m0_rresp, m0_rvalid,
                m1_arready, m1_rdata, m1_rresp, m1_rvalid, m1_awready, m1_wready, m1_bresp,
                m1_bvalid, grant, busy};
  typedef struct {
    logic m0v, m1arv, m1awv, srv, sbv;
    logic [1:0] g;
    logic b, sar, saw;
  } vec_t;
  vec_t tbl[13];
  task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  task automatic clr();
    {m0_arvalid, m0_araddr, m0_rready} = '0;
    {m1_arvalid, m1_araddr, m1_load_unsign, m1_arsize, m1_rready} = '0;
    {m1_awvalid, m1_awaddr, m1_wvalid, m1_wdata, m1_wstrb, m1_bready} = '0;
    {s_arready, s_rdata, s_rresp, s_rvalid, s_awready, s_wready, s_bresp, s_bvalid} = '0;
  endtask
  task automatic do_reset();
    reset = 1;
    clr();
    @(negedge clk);
    reset = 0;
  endtask
  // Reference view: the owner (0 none, 1 m0 read, 2 m1 read, 3 m1 write) decides which
  // master's fields appear on which side; everything else is zero.
  function automatic logic [214:0] exp_vec();
    logic sarv, slu, srr, sawv, swv, sbr, m0arr, m0rr, m0rv;
    logic m1arr, m1rr, m1rv, m1awr, m1wr, m1br, m1bv, bz;
    logic [31:0] saa, saw, swd, sws, m0rd, m1rd;
    logic [3:0] ssz;
    logic [1:0] g;
    {sarv, slu, srr, sawv, swv, sbr, m0arr, m0rr, m0rv} = '0;
    {m1arr, m1rr, m1rv, m1awr, m1wr, m1br, m1bv, bz} = '0;
    {saa, saw, swd, sws, m0rd, m1rd, ssz, g} = '0;
    if (owner == 1) begin
      sarv = m0_arvalid; saa = m0_araddr; slu = 1; ssz = 4; srr = m0_rready;
      m0arr = s_arready; m0rd = s_rdata; m0rr = s_rresp; m0rv = s_rvalid; g = 1;
    end
    if (owner == 2) begin
      sarv = m1_arvalid; saa = m1_araddr; slu = m1_load_unsign; ssz = m1_arsize; srr = m1_rready;
      m1arr = s_arready; m1rd = s_rdata; m1rr = s_rresp; m1rv = s_rvalid; g = 2;
    end
    if (owner == 3) begin
      sawv = m1_awvalid; saw = m1_awaddr; swv = m1_wvalid; swd = m1_wdata; sws = m1_wstrb;
      sbr = m1_bready; m1awr = s_awready; m1wr = s_wready; m1br = s_bresp; m1bv = s_bvalid; g = 2;
    end
    bz = owner != 0;
    return {sarv, saa, slu, ssz, srr, sawv, saw, swv, swd, sws, sbr, m0arr, m0rd, m0rr, m0rv,
            m1arr, m1rd, m1rr, m1rv, m1awr, m1wr, m1br, m1bv, g, bz};
  endfunction
  task automatic model_step();
    int pick;
    pick = -1;
    if (reset) begin
      owner = 0;
      last = 1;
    end else if (owner == 0) begin
      if (m0_arvalid && (m1_arvalid || m1_awvalid)) pick = 1 - last;
      else if (m0_arvalid) pick = 0;
      else if (m1_arvalid || m1_awvalid) pick = 1;
      if (pick >= 0) begin
        owner = pick == 0 ? 1 : (m1_awvalid ? 3 : 2);
        last = pick;
      end
    end else if ((owner == 1 && s_rvalid && m0_rready) || (owner == 2 && s_rvalid && m1_rready) ||
                 (owner == 3 && s_bvalid && m1_bready)) owner = 0;
  endtask
  initial begin
    tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 1, 0, 1, 1, 1, 0};
    tbl[2]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 1, 0, 1, 0, 2, 1, 1, 0};
    tbl[4]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 1, 0, 1, 0, 1, 1, 1, 0};
    tbl[6]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{1, 1, 0, 1, 0, 2, 1, 1, 0};
    tbl[8]  = '{0, 1, 1, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{0, 1, 1, 0, 1, 2, 1, 0, 1};
    tbl[10] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{0, 1, 0, 1, 0, 2, 1, 1, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    reset = 1;
    clr();
    @(negedge clk);
    m0_arvalid = 1; m1_arvalid = 1; m1_awvalid = 1; s_rvalid = 1; s_bvalid = 1;
    s_rdata = 32'hDEADBEEF; s_arready = 1; m0_rready = 1;
    #1 chk("reset_idle", act, '0);
    do_reset();
    for (int i = 0; i < 13; i++) begin
      m0_arvalid = tbl[i].m0v; m1_arvalid = tbl[i].m1arv; m1_awvalid = tbl[i].m1awv;
      s_rvalid = tbl[i].srv; s_bvalid = tbl[i].sbv;
      m0_rready = 1; m1_rready = 1; m1_bready = 1;
      #1 chk($sformatf("table%0d", i), {grant, busy, s_arvalid, s_awvalid},
             {tbl[i].g, tbl[i].b, tbl[i].sar, tbl[i].saw});
      @(negedge clk);
    end
    do_reset();
    m0_arvalid = 1; m0_araddr = 32'h80000000; m0_rready = 1; s_arready = 1;
    #1 chk("fetch_idle", grant, 0);
    @(negedge clk);
    s_rdata = 32'h12345678; s_rvalid = 1;
    #1 chk("fetch_grant", grant, 1);
    chk("fetch_addr", s_araddr, 32'h80000000);
    chk("fetch_size_uns", {s_arsize, s_load_unsign}, {4'd4, 1'b1});
    chk("fetch_rdata", {m0_rdata, m0_rvalid, m0_arready}, {32'h12345678, 1'b1, 1'b1});
    @(negedge clk);
    m0_arvalid = 0; s_rvalid = 0;
    #1 chk("fetch_done", {busy, grant}, 0);
    do_reset();
    m1_awvalid = 1; m1_awaddr = 32'h80001000; m1_wvalid = 1; m1_wdata = 32'hA5; m1_wstrb = 1;
    m1_bready = 1; s_awready = 1; s_wready = 1; s_arready = 1;
    @(negedge clk);
    m0_arvalid = 1;
    #1 chk("wr_grant", grant, 2);
    chk("wr_fwd", {s_awaddr, s_wdata, s_wstrb, s_awvalid, s_wvalid},
        {32'h80001000, 32'hA5, 32'd1, 1'b1, 1'b1});
    chk("wr_m0_held", {m0_arready, s_arvalid}, 0);
    @(negedge clk);
    s_bvalid = 1;
    #1 chk("wr_bvalid", {m1_bvalid, m0_arready}, 2'b10);
    @(negedge clk);
    s_bvalid = 0; m1_awvalid = 0; m1_wvalid = 0;
    #1 chk("wr_done", busy, 0);
    @(negedge clk);
    #1 chk("wr_then_m0", {grant, m0_arready}, {2'd1, 1'b1});
    do_reset();
    m1_arvalid = 1; m1_araddr = 32'h80000040;
    @(negedge clk);
    s_rvalid = 1; s_rdata = 32'h55AA55AA; s_arready = 1;
    #1 chk("rst_rd1", grant, 2);
    reset = 1;
    @(negedge clk);
    reset = 0;
    #1 chk("rst_mid_rd1", act, '0);
    do_reset();
    m1_arvalid = 1; m1_arsize = 2; m1_load_unsign = 0; m1_araddr = 32'h80002002;
    m1_rready = 1; s_arready = 1;
    @(negedge clk);
    m0_arvalid = 1;
    #1 chk("half_req", {s_arsize, s_load_unsign, s_araddr}, {4'd2, 1'b0, 32'h80002002});
    chk("half_ready", {m1_arready, m0_arready}, 2'b10);
    @(negedge clk);
    s_rvalid = 1; s_rdata = 32'hFFFF8001;
    #1 chk("half_rdata", m1_rdata, 32'hFFFF8001);
    chk("half_m0_held", {m0_arready, m0_rvalid, m0_rdata}, 0);
    do_reset();
    owner = 0;
    last = 1;
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 49) == 0;
      m0_arvalid = $urandom_range(0, 2) != 0; m0_araddr = $urandom;
      m0_rready = $urandom_range(0, 2) != 0;
      m1_arvalid = 1'($urandom_range(0, 1)); m1_araddr = $urandom;
      m1_load_unsign = 1'($urandom_range(0, 1)); m1_arsize = 4'(1 << $urandom_range(0, 2));
      m1_rready = $urandom_range(0, 2) != 0;
      m1_awvalid = 1'($urandom_range(0, 1)); m1_awaddr = $urandom;
      m1_wvalid = 1'($urandom_range(0, 1)); m1_wdata = $urandom; m1_wstrb = $urandom;
      m1_bready = $urandom_range(0, 2) != 0;
      s_arready = 1'($urandom_range(0, 1)); s_rdata = $urandom; s_rresp = 1'($urandom_range(0, 1));
      s_rvalid = 1'($urandom_range(0, 1)); s_awready = 1'($urandom_range(0, 1));
      s_wready = 1'($urandom_range(0, 1)); s_bresp = 1'($urandom_range(0, 1));
      s_bvalid = 1'($urandom_range(0, 1));
      #1 chk("rand", act, exp_vec());
      model_step();
      @(negedge clk);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master to one-slave arbiter for the shared simulation memory.
- Master 0 is the instruction fetch unit (read only). Master 1 is the load/store unit (read and write).
- Selects one master, routes its read or write transaction through to the memory slave, and holds the grant until that transaction's response handshake completes.
- Sits between the fetch/LSU stages and the memory model in the core top level.

Parameters:
- ADDR_W, 32, address width of all ar/aw channels.
- DATA_W, 32, data width of the r and w channels.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_arvalid/m0_araddr/m0_arready  in/in/out  1/ADDR_W/1  IFU read address
- m0_rdata/m0_rresp/m0_rvalid/m0_rready  out/out/out/in  DATA_W/1/1/1  IFU read data
- m1_arvalid/m1_araddr/m1_load_unsign/m1_arsize/m1_arready  in/in/in/in/out  1/ADDR_W/1/4/1  LSU read address; arsize is the byte count 1/2/4
- m1_rdata/m1_rresp/m1_rvalid/m1_rready  out/out/out/in  DATA_W/1/1/1  LSU read data
- m1_awvalid/m1_awaddr/m1_awready  in/in/out  1/ADDR_W/1  LSU write address
- m1_wvalid/m1_wdata/m1_wstrb/m1_wready  in/in/in/out  1/DATA_W/32/1  LSU write data; wstrb carries the byte length
- m1_bresp/m1_bvalid/m1_bready  out/out/in  1/1/1  LSU write response
- s_*  same set of 19 signals as m1_*, directions reversed  memory slave side
- grant  out  2  0 = none, 1 = m0, 2 = m1 (performance counters)
- busy  out  1  high in any state other than IDLE

Behaviour:
- States:
  - IDLE
  - RD0: m0 read owns the slave
  - RD1: m1 read owns the slave
  - WR1: m1 write owns the slave
- Reset: state = IDLE; last = m1, so m0 wins the first tie. A reset during any state returns to IDLE on the next edge, with no handshake completion implied.
- Outputs in IDLE:
  - All s_* valids are 0. s_rready and s_bready are 0.
  - All m* readys and m* valids are 0. All m* data/resp outputs are 0.
  - grant = 0, busy = 0.
- IDLE arbitration, evaluated every cycle:
  - Requests are req0 = m0_arvalid and req1 = m1_arvalid | m1_awvalid.
  - Only one requester: grant it. Both requesting: grant the master that is not `last`. The grant register `last` updates on entering RD0/RD1/WR1.
  - An m1 grant goes to WR1 if m1_awvalid, else to RD1. Write beats read if both are asserted.
- Grant latency: a request seen in IDLE at cycle N moves the state at edge N+1. The slave sees the forwarded valid in cycle N+1. The arbiter adds no other latency.
- Owned states (RD0/RD1/WR1):
  - The granted master's channel signals connect combinationally to s_*, in both directions.
  - In RD0: s_load_unsign = 1 and s_arsize = 4, so fetches are unsigned word reads.
  - All aw/w/b signals toward the slave are 0 in RD0/RD1. All ar/r signals toward the slave are 0 in WR1.
  - The non-granted master sees all readys = 0, rvalid/bvalid = 0, data = 0.
- Completion:
  - RD*: s_rvalid & s_rready → IDLE at the next edge.
  - WR1: s_bvalid & s_bready → IDLE at the next edge.
  - The response is delivered to the master in the same cycle it is presented.
- Masters must hold their valids and address until the response handshake. A master that drops its valid early does not release the grant: the state persists until completion.
- Minimum occupancy is 2 cycles per transaction (grant cycle plus handshake), followed by 1 IDLE cycle between back-to-back grants. There are no outstanding transactions or reordering.
- The same master re-requesting is allowed. It still wins only when the other master is idle or it is its round-robin turn.
- busy = (state != IDLE). grant = 1 in RD0, 2 in RD1/WR1.

Decomposition:
- Shared package mem_arb_pkg holds:
  - State enum: IDLE, RD0, RD1, WR1.
  - Grant ID constants: GNT_NONE = 0, GNT_M0 = 1, GNT_M1 = 2.
  - Fetch constants: FETCH_SIZE = 4, FETCH_UNSIGNED = 1.
- One sub-module, rr_pick2: 2-input round-robin picker (req0, req1, last → gnt), purely combinational. The state register and the channel muxing stay in mem_arbiter.

Test Plan:
- Reset, then m0_arvalid with m0_araddr = 0x80000000 → grant = 1 the next cycle; s_araddr = 0x80000000, s_arsize = 4, s_load_unsign = 1; m0_rdata = slave data; IDLE one cycle after the r handshake.
- Tie: m0_arvalid and m1_arvalid both asserted continuously → grants alternate m0, m1, m0, m1 over 4 transactions; m0 wins first after reset.
- m1 byte write: awaddr = 0x80001000, wdata = 0xA5, wstrb = 1 → state WR1; s_wstrb = 1; m1_bvalid forwarded; m0_arvalid asserted mid-write sees m0_arready = 0 until IDLE.
- m1_arvalid and m1_awvalid asserted together → WR1 chosen; the read is served by the next grant.
- Reset asserted while in RD1 with s_rvalid pending → state = IDLE and busy = 0 after one edge; all m* outputs 0.
- m1 signed halfword read: arsize = 2, load_unsign = 0, slave returns 0xFFFF8001 → m1_rdata = 0xFFFF8001 unmodified; m0 held off (m0_arready = 0) throughout.
